// File: rtl/clk_div_pkg.sv
// Shared FSM state encoding and ratio legality check for the clock divider.
// No logic of its own; imported by the divider top.
package clk_div_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_PEND = 2'd2,
        ST_STOP = 2'd3
    } state_e;

    // A usable ratio is even and at least 2 (zero is even, so it needs its own test).
    function automatic logic ratio_illegal(input logic [31:0] ratio);
        return ratio[0] || (ratio < 32'd2);
    endfunction

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and toggle flop producing the divided clock and its tick.
// Latency: clk_div and tick update on the edge the count wraps; no backpressure (free-running while run_i).
module clk_div_core #(
    parameter int CW = 7
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic [CW-1:0] half_i,
    input  logic          run_i,
    input  logic          load_i,
    output logic          clk_div_o,
    output logic          tick_o,
    output logic [CW-1:0] phase_o
);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;
    logic          wrap;

    // >= rather than == so a shrunk half-period can never let the count run past its end.
    assign wrap = (cnt_q >= half_i - CW'(1));

    always_comb begin
        cnt_d  = cnt_q;
        clk_d  = clk_q;
        tick_d = 1'b0;
        if (!run_i) begin
            cnt_d  = '0;
            clk_d  = 1'b0;
            tick_d = clk_q;
        end else if (wrap) begin
            cnt_d  = '0;
            clk_d  = ~clk_q;
            tick_d = 1'b1;
        end else if (load_i) begin
            cnt_d  = '0;
        end else begin
            cnt_d  = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            tick_q <= tick_d;
        end
    end

    assign clk_div_o = clk_q;
    assign tick_o    = tick_q;
    assign phase_o   = cnt_q;

endmodule

// File: rtl/clk_div_sched.sv
// Glitch-free programmable 50% clock divider with run/stop scheduling; CLK_DIV_SCHED_EDGECNT_EN adds edge_cnt.
// Latency: ratio takes effect next cycle in IDLE, else at the next 1->0 toggle; cfg_ready low while a ratio is pending or stopping.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic             cfg_valid,
    input  logic [DIV_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             cfg_err,
    output logic             clk_div,
    output logic             div_tick,
    output logic [DIV_W-1:0] cur_div,
    output logic             busy
`ifdef CLK_DIV_SCHED_EDGECNT_EN
    ,
    output logic [15:0]      edge_cnt
`endif
);

    localparam int CW = DIV_W - 1;

    state_e           state_q, state_d;
    logic [DIV_W-1:0] cur_div_q, cur_div_d;
    logic [DIV_W-1:0] pend_div_q, pend_div_d;
    logic             pend_vld_q, pend_vld_d;
    logic             cfg_err_q;
    logic             cfg_hs, cfg_bad, cfg_ok;
    logic             load, apply_pend, core_run;
    logic             end_of_half, stop_now;
    logic [CW-1:0]    half, phase;

    assign cfg_ready   = (state_q == ST_IDLE) || (state_q == ST_RUN);
    assign busy        = (state_q != ST_IDLE);
    assign cfg_hs      = cfg_valid & cfg_ready;
    assign cfg_bad     = cfg_hs & ratio_illegal(32'(cfg_div));
    assign cfg_ok      = cfg_hs & ~cfg_bad;
    assign half        = cur_div_q[DIV_W-1:1];
    assign end_of_half = (phase >= half - CW'(1));
    // Stopping is only safe while low, or on the very edge that ends a high phase.
    assign stop_now    = !clk_div || end_of_half;
    // Drop run on the edge we head to IDLE so the core cannot start a new phase it would then truncate.
    assign core_run    = busy && (state_d != ST_IDLE);

    always_comb begin
        state_d    = state_q;
        cur_div_d  = cur_div_q;
        pend_div_d = pend_div_q;
        pend_vld_d = pend_vld_q;
        load       = 1'b0;
        apply_pend = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cfg_ok) begin
                    cur_div_d = cfg_div;
                    load      = 1'b1;
                end
                if (en) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (!en && stop_now) begin
                    state_d = ST_IDLE;
                    if (cfg_ok) begin
                        cur_div_d = cfg_div;
                        load      = 1'b1;
                    end
                end else begin
                    if (cfg_ok) begin
                        pend_div_d = cfg_div;
                        pend_vld_d = 1'b1;
                    end
                    if (!en)         state_d = ST_STOP;
                    else if (cfg_ok) state_d = ST_PEND;
                end
            end
            ST_PEND: begin
                // With en low on the falling edge the stop completes here, so go straight to IDLE.
                if (!en && stop_now) begin
                    state_d    = ST_IDLE;
                    apply_pend = 1'b1;
                end else if (clk_div && end_of_half) begin
                    state_d    = ST_RUN;
                    apply_pend = 1'b1;
                end else if (!en) begin
                    state_d    = ST_STOP;
                end
            end
            ST_STOP: begin
                if (end_of_half) begin
                    state_d    = ST_IDLE;
                    apply_pend = pend_vld_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (apply_pend) begin
            cur_div_d  = pend_div_q;
            pend_vld_d = 1'b0;
            load       = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            cur_div_q  <= DIV_W'(DEFAULT_DIV);
            pend_div_q <= '0;
            pend_vld_q <= 1'b0;
            cfg_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cur_div_q  <= cur_div_d;
            pend_div_q <= pend_div_d;
            pend_vld_q <= pend_vld_d;
            cfg_err_q  <= cfg_bad;
        end
    end

    clk_div_core #(.CW(CW)) u_core (
        .clk       (clk),
        .reset_n   (reset_n),
        .half_i    (half),
        .run_i     (core_run),
        .load_i    (load),
        .clk_div_o (clk_div),
        .tick_o    (div_tick),
        .phase_o   (phase)
    );

    assign cfg_err = cfg_err_q;
    assign cur_div = cur_div_q;

`ifdef CLK_DIV_SCHED_EDGECNT_EN
    logic [15:0] edge_cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            edge_cnt_q <= '0;
        end else if (load) begin
            edge_cnt_q <= '0;
        end else if (core_run && !clk_div && end_of_half) begin
            edge_cnt_q <= edge_cnt_q + 16'd1;
        end
    end

    assign edge_cnt = edge_cnt_q;
`endif

endmodule
